// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline (between exe_stage and wb_stage).
// Latches the EXE payload, completes loads from the synchronous data SRAM
// (byte/half select, sign/zero extension, LWL/LWR merge), and produces the
// MEM->WB bus and the MEM forwarding bus. An exception/eret committing in WB
// (ws_flush) kills whatever MEM holds and drops the incoming EXE instruction.
//
// The SRAM read data is only valid in the first cycle a load spends in MEM.
// A one-entry hold buffer keeps that word if WB stalls the stage.

module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 113,
  parameter int MS_TO_WS_BUS_WD = 76,
  parameter int FW_BUS_WD       = 38
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus,
  output logic                       out_ms_valid,
  input  logic                       ws_flush,
  output logic                       ms_excp_pending
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       buf_valid;
  logic [31:0]                buf_data;

  logic                       ms_ready_go;

  logic                       ms_excp;
  logic [4:0]                 ms_execode;
  logic [2:0]                 ms_load_op;
  logic [1:0]                 ms_boff;
  logic [31:0]                ms_rt_val;
  logic                       ms_gr_we;
  logic [4:0]                 ms_dest;
  logic [31:0]                ms_alu_res;
  logic [31:0]                ms_pc;

  logic [31:0]                rdata;
  logic [7:0]                 sel_byte;
  logic [15:0]                sel_half;
  logic [31:0]                load_result;
  logic [31:0]                final_result;
  logic                       out_gr_we;

  // Unpack the latched EXE payload into named fields.
  always_comb begin
    ms_excp    = bus_r[112];
    ms_execode = bus_r[111:107];
    ms_load_op = bus_r[106:104];
    ms_boff    = bus_r[103:102];
    ms_rt_val  = bus_r[101:70];
    ms_gr_we   = bus_r[69];
    ms_dest    = bus_r[68:64];
    ms_alu_res = bus_r[63:32];
    ms_pc      = bus_r[31:0];
  end

  // Handshake: MEM never stalls on its own, so it only waits on WB.
  always_comb begin
    ms_ready_go    = 1'b1;
    ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush;
    out_ms_valid   = ms_valid;
  end

  // Stage valid bit: a flush empties the stage and refuses the EXE instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid <= 1'b0;
    end else if (ws_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Payload register: only overwritten when a real instruction is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_r <= '0;
    end else if (!ws_flush && ms_allowin && es_to_ms_valid) begin
      bus_r <= es_to_ms_bus;
    end
  end

  // Hold buffer: capture the SRAM word on the first stalled cycle, release it
  // when the instruction moves on to WB or is flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (ws_flush || ws_allowin) begin
      buf_valid <= 1'b0;
    end else if (ms_valid && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // Pick the live SRAM word or the held copy, then the addressed byte and half.
  always_comb begin
    rdata = buf_valid ? buf_data : data_sram_rdata;
    unique case (ms_boff)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    // Halfword loads are always aligned, so boff[1] alone selects the half.
    sel_half = ms_boff[1] ? rdata[31:16] : rdata[15:0];
  end

  // Load alignment and extension, including the LWL/LWR partial-word merges.
  always_comb begin
    load_result = ms_alu_res;
    unique case (ms_load_op)
      LD_NONE: load_result = ms_alu_res;
      LD_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  load_result = {24'd0, sel_byte};
      LD_LH:   load_result = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  load_result = {16'd0, sel_half};
      LD_LW:   load_result = rdata;
      LD_LWL: begin
        unique case (ms_boff)
          2'd0:    load_result = {rdata[7:0],  ms_rt_val[23:0]};
          2'd1:    load_result = {rdata[15:0], ms_rt_val[15:0]};
          2'd2:    load_result = {rdata[23:0], ms_rt_val[7:0]};
          default: load_result = rdata;
        endcase
      end
      LD_LWR: begin
        unique case (ms_boff)
          2'd0:    load_result = rdata;
          2'd1:    load_result = {ms_rt_val[31:8 + 16], rdata[31:8]};
          2'd2:    load_result = {ms_rt_val[31:16],     rdata[31:16]};
          default: load_result = {ms_rt_val[31:8],      rdata[31:24]};
        endcase
      end
      default: load_result = ms_alu_res;
    endcase
  end

  // An excepting instruction must not write the register file; its result
  // field carries alu_res (the faulting address for AdEL/AdES) instead.
  always_comb begin
    final_result = ms_excp ? ms_alu_res : load_result;
    out_gr_we    = ms_gr_we && !ms_excp;
  end

  // Output buses toward WB and decode.
  always_comb begin
    ms_to_ws_bus    = {ms_excp, ms_execode, out_gr_we, ms_dest, final_result, ms_pc};
    ms_to_ds_fw_bus = {ms_valid && out_gr_we, ms_dest, final_result};
    ms_excp_pending = ms_valid && ms_excp;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.

module tb_mem_stage;

  logic          clk;
  logic          reset;
  logic          es_to_ms_valid;
  logic [112:0]  es_to_ms_bus;
  logic          ms_allowin;
  logic          ws_allowin;
  logic          ms_to_ws_valid;
  logic [75:0]   ms_to_ws_bus;
  logic [31:0]   data_sram_rdata;
  logic [37:0]   ms_to_ds_fw_bus;
  logic          out_ms_valid;
  logic          ws_flush;
  logic          ms_excp_pending;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the instruction sitting in MEM, whether this is
  // its first cycle there, and the SRAM word it saw on that first cycle.
  logic          m_valid;
  logic [112:0]  m_ins;
  logic          m_first;
  logic [31:0]   m_data;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_allowin      (ms_allowin),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ds_fw_bus (ms_to_ds_fw_bus),
    .out_ms_valid    (out_ms_valid),
    .ws_flush        (ws_flush),
    .ms_excp_pending (ms_excp_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [112:0] mk_bus(input logic excp, input logic [4:0] code,
                                          input logic [2:0] op, input logic [1:0] boff,
                                          input logic [31:0] rt, input logic we,
                                          input logic [4:0] dest, input logic [31:0] alu,
                                          input logic [31:0] pc);
    return {excp, code, op, boff, rt, we, dest, alu, pc};
  endfunction

  // Load semantics from the ISA rules, using shifts and masks.
  function automatic logic [31:0] ref_result(input logic [112:0] ins, input logic [31:0] rd);
    logic        excp;
    logic [2:0]  op;
    int unsigned k;
    logic [31:0] rt, alu, b, h;
    logic [63:0] wide;
    excp = ins[112];
    op   = ins[106:104];
    k    = int'(ins[103:102]);
    rt   = ins[101:70];
    alu  = ins[63:32];
    b    = (rd >> (8 * k)) & 32'hFF;
    h    = (rd >> (16 * (k / 2))) & 32'hFFFF;
    if (excp) return alu;
    case (op)
      3'd1: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd2: return b;
      3'd3: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4: return h;
      3'd5: return rd;
      3'd6: begin
        wide = ({32'd0, rd} << (8 * (3 - k))) | ({32'd0, rt} & ((64'd1 << (8 * (3 - k))) - 64'd1));
        return wide[31:0];
      end
      3'd7: return (rd >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
      default: return alu;
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_ins   = '0;
    m_first = 1'b0;
    m_data  = '0;
  endtask

  // Compare every observable output against the model for the current cycle.
  task automatic compare_all();
    logic [31:0] rd, res;
    logic        we;
    rd  = m_first ? data_sram_rdata : m_data;
    res = ref_result(m_ins, rd);
    we  = m_ins[69] && !m_ins[112];
    check_val("allowin", ms_allowin, !m_valid || ws_allowin);
    check_val("to_ws_valid", ms_to_ws_valid, m_valid && !ws_flush);
    check_val("out_ms_valid", out_ms_valid, m_valid);
    check_val("excp_pending", ms_excp_pending, m_valid && m_ins[112]);
    check_val("fw_we", ms_to_ds_fw_bus[37], m_valid && we);
    if (m_valid) begin
      check_val("ws_bus", ms_to_ws_bus, {m_ins[112:107], we, m_ins[68:64], res, m_ins[31:0]});
      check_val("fw_bus", ms_to_ds_fw_bus[36:0], {m_ins[68:64], res});
    end
  endtask

  // Update the model with what the clock edge does to the stage contents.
  task automatic model_edge();
    if (!reset) begin
      model_clear();
    end else if (ws_flush) begin
      m_valid = 1'b0;
      m_first = 1'b0;
    end else if (!m_valid || ws_allowin) begin
      m_valid = es_to_ms_valid;
      if (es_to_ms_valid) begin
        m_ins   = es_to_ms_bus;
        m_first = 1'b1;
      end
    end else if (m_first) begin
      m_data  = data_sram_rdata;
      m_first = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge,
  // then leave 1 time unit before the caller drives new inputs.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    ws_allowin      = 1'b1;
    data_sram_rdata = '0;
    ws_flush        = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    model_clear();
    #2;
    check_val("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check_val("rst_allowin", ms_allowin, 1'b1);
    check_val("rst_fw_we", ms_to_ds_fw_bus[37], 1'b0);
    check_val("rst_excp_pending", ms_excp_pending, 1'b0);
    @(posedge clk);
    model_edge();
    #1;
    reset = 1'b1;
    tick();

    // LB and LBU on the top byte, each reaching WB one cycle after EXE.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b0, 5'd0, 3'd1, 2'd3, 32'h0, 1'b1, 5'd8, 32'h1003, 32'hBFC0_0000);
    tick();
    es_to_ms_bus    = mk_bus(1'b0, 5'd0, 3'd2, 2'd3, 32'h0, 1'b1, 5'd9, 32'h1003, 32'hBFC0_0004);
    data_sram_rdata = 32'h80FF_1234;
    #2;
    check_val("lb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    check_val("lb_valid", ms_to_ws_valid, 1'b1);
    tick();
    es_to_ms_bus = mk_bus(1'b0, 5'd0, 3'd6, 2'd1, 32'h1122_3344, 1'b1, 5'd10, 32'h2001, 32'hBFC0_0008);
    #2;
    check_val("lbu_result", ms_to_ws_bus[63:32], 32'h0000_0080);
    tick();

    // LWL and LWR merges with boff=1.
    es_to_ms_bus    = mk_bus(1'b0, 5'd0, 3'd7, 2'd1, 32'h1122_3344, 1'b1, 5'd11, 32'h2001, 32'hBFC0_000C);
    data_sram_rdata = 32'hAABB_CCDD;
    #2;
    check_val("lwl_result", ms_to_ws_bus[63:32], 32'hCCDD_3344);
    tick();
    es_to_ms_bus = mk_bus(1'b0, 5'd0, 3'd5, 2'd0, 32'h0, 1'b1, 5'd12, 32'h3000, 32'hBFC0_0010);
    #2;
    check_val("lwr_result", ms_to_ws_bus[63:32], 32'h11AA_BBCC);
    tick();

    // LW held for three stalled cycles while the SRAM output turns to garbage.
    es_to_ms_bus    = mk_bus(1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 1'b1, 5'd13, 32'h5555, 32'hBFC0_0014);
    data_sram_rdata = 32'hCAFE_F00D;
    ws_allowin      = 1'b0;
    #2;
    check_val("stall_allowin_1", ms_allowin, 1'b0);
    tick();
    for (int i = 2; i <= 3; i++) begin
      data_sram_rdata = $urandom();
      #2;
      check_val("stall_allowin_n", ms_allowin, 1'b0);
      check_val("stall_word_n", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
      tick();
    end
    ws_allowin      = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    #2;
    check_val("stall_word_out", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    tick();

    // Excepting instruction with gr_we=1.
    es_to_ms_bus = mk_bus(1'b1, 5'h04, 3'd5, 2'd0, 32'h0, 1'b1, 5'd14, 32'h0000_0003, 32'hBFC0_0018);
    tick();
    es_to_ms_valid = 1'b0;
    #2;
    check_val("excp_bit", ms_to_ws_bus[75], 1'b1);
    check_val("excp_code", ms_to_ws_bus[74:70], 5'h04);
    check_val("excp_gr_we", ms_to_ws_bus[69], 1'b0);
    check_val("excp_fw_we", ms_to_ds_fw_bus[37], 1'b0);
    check_val("excp_pending", ms_excp_pending, 1'b1);
    tick();

    // Flush while MEM is full and EXE is offering another instruction.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1'b0, 5'd0, 3'd5, 2'd0, 32'h0, 1'b1, 5'd15, 32'h40, 32'hBFC0_001C);
    tick();
    es_to_ms_bus = mk_bus(1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 1'b1, 5'd16, 32'h44, 32'hBFC0_0020);
    ws_flush     = 1'b1;
    ws_allowin   = 1'b0;
    #2;
    check_val("flush_to_ws_valid", ms_to_ws_valid, 1'b0);
    tick();
    ws_flush       = 1'b0;
    es_to_ms_valid = 1'b0;
    ws_allowin     = 1'b1;
    #2;
    check_val("flush_ms_valid", out_ms_valid, 1'b0);
    check_val("flush_buf_valid", dut.buf_valid, 1'b0);
    tick();

    // Reset asserted in the middle of a stall with the hold buffer full.
    es_to_ms_valid  = 1'b1;
    es_to_ms_bus    = mk_bus(1'b0, 5'd0, 3'd5, 2'd0, 32'h0, 1'b1, 5'd17, 32'h80, 32'hBFC0_0024);
    tick();
    es_to_ms_valid  = 1'b0;
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    tick();
    #2;
    check_val("pre_rst_buf_valid", dut.buf_valid, 1'b1);
    reset = 1'b0;
    model_clear();
    #1;
    check_val("mid_rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check_val("mid_rst_allowin", ms_allowin, 1'b1);
    check_val("mid_rst_fw_we", ms_to_ds_fw_bus[37], 1'b0);
    check_val("mid_rst_excp_pending", ms_excp_pending, 1'b0);
    check_val("mid_rst_ms_valid", out_ms_valid, 1'b0);
    check_val("mid_rst_ws_bus", ms_to_ws_bus, 76'd0);
    check_val("mid_rst_buf_valid", dut.buf_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    model_edge();
    #1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] op;
      logic [1:0] boff;
      op   = 3'($urandom_range(0, 7));
      boff = 2'($urandom_range(0, 3));
      if (op == 3'd3 || op == 3'd4) boff[0] = 1'b0;
      es_to_ms_valid  = ($urandom_range(0, 3) != 0);
      es_to_ms_bus    = mk_bus(($urandom_range(0, 9) == 0), 5'($urandom()), op, boff,
                               $urandom(), 1'($urandom()), 5'($urandom()), $urandom(), $urandom());
      ws_allowin      = ($urandom_range(0, 9) < 7);
      ws_flush        = ($urandom_range(0, 19) == 0);
      data_sram_rdata = $urandom();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
